pixel_fb_writer: RTL and testbench
==================================

Name: pixel_fb_writer

Overview:
- Downstream stage of the 160x120 drawing FSMs. It consumes their (x, y, color, writeEn) pixel stream and converts each pixel to a linear framebuffer address (y*160 + x).
- Buffers pixels in a small FIFO so framebuffer-port back-pressure does not lose pixels.
- Drives a single-port framebuffer write interface with valid/stall handshaking.
- Provides a full-screen clear sweep on request.

Parameters:
- X_MAX, 160, horizontal resolution; x >= X_MAX is out of range.
- Y_MAX, 120, vertical resolution; y >= Y_MAX is out of range.
- FIFO_DEPTH, 4, pixel FIFO entries; must be a power of 2, minimum 2.
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= X_MAX*Y_MAX.
- CLEAR_COLOR, 9'd0, color written by the clear sweep.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_x  in  8  pixel column
- in_y  in  7  pixel row
- in_color  in  9  pixel color, 3 bits per channel
- in_valid  in  1  pixel write strobe (upstream writeEn)
- in_ready  out  1  pixel will be accepted this cycle
- clear_req  in  1  single-cycle clear request
- clear_busy  out  1  drain or clear sweep in progress
- fb_addr  out  ADDR_W  framebuffer write address
- fb_data  out  9  framebuffer write data
- fb_we  out  1  write valid
- fb_stall  in  1  framebuffer cannot accept a write this cycle
- dropped_cnt  out  8  saturating count of discarded pixels

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - fb_we=0, fb_addr=0, fb_data=0.
  - dropped_cnt=0, clear_busy=0.
  - FIFO empty, state IDLE, sweep counter 0.
- Reset asserted mid-operation (including mid-clear) aborts everything. From the next cycle the reset values hold and no further writes are issued.
- Address: y*X_MAX + x, computed combinationally at accept and stored in the FIFO with the color. With the default X_MAX this is (y<<7)+(y<<5)+x, zero-extended to ADDR_W.
- Accept rules:
  - in_ready = (state==IDLE) && !fifo_full.
  - A pixel is accepted on an edge where in_valid && in_ready && x<X_MAX && y<Y_MAX.
- Discard rules:
  - in_valid with an out-of-range coordinate is discarded regardless of in_ready.
  - in_valid while in_ready=0 is discarded.
  - Each discard increments dropped_cnt, which saturates at 255.
- Output stage:
  - fb_addr, fb_data and fb_we form a registered output stage.
  - A write completes on an edge where fb_we && !fb_stall.
  - While fb_we && fb_stall, fb_addr, fb_data and fb_we hold unchanged.
  - The stage loads from the FIFO head (or the sweep counter) when (!fb_we || !fb_stall) and a source is available; otherwise fb_we clears.
- Latency and throughput:
  - Pixel accepted at edge N into an empty FIFO with the output stage idle: fb_we=1 with that pixel from edge N+1.
  - Sustained throughput is 1 pixel per cycle.
  - Pixels are written in acceptance order.
- State machine:
  - IDLE -> DRAIN on clear_req. A pixel presented on the same edge is still accepted, because in_ready was high.
  - DRAIN -> CLEAR once the FIFO is empty and no write is pending (fb_we=0, or a write completes this edge).
  - CLEAR: issues addresses 0 .. X_MAX*Y_MAX-1 with data CLEAR_COLOR, advancing one per completed write. Moves to IDLE once the write to the last address completes.
  - clear_busy=1 in DRAIN and CLEAR. clear_req outside IDLE is ignored.
- FIFO boundaries:
  - Full: no push; in_ready=0.
  - Simultaneous push and pop when full is not possible, because in_ready already gates the push.
  - Simultaneous push and pop otherwise: occupancy unchanged.
  - Empty: no pop.

Decomposition:
- Shared vga package holds:
  - X_MAX/Y_MAX (160/120), ADDR_W, the 9-bit color width.
  - Address-compute function.
  - State encoding: IDLE, DRAIN, CLEAR.
- One sub-module: sync_fifo.
  - Parameterised width and depth; push, pop, full, empty.
  - Synchronous active-high reset; first-word data presented combinationally at the head.
  - Instantiated with width ADDR_W+9.

Test Plan:
- After reset, pixel (x=5, y=2, color=9'h1A5) with fb_stall=0 -> fb_we=1 for exactly one cycle from the next edge, fb_addr=325, fb_data=9'h1A5; dropped_cnt stays 0.
- Pixel (159,119) -> fb_addr=19199. Pixel (160,0) and pixel (0,120) -> no fb_we, dropped_cnt=2.
- fb_stall held high, 6 back-to-back pixels -> 1 pixel held in the output stage and 4 in the FIFO; in_ready=0 after the 5th accept; 6th discarded, dropped_cnt=1. Release fb_stall -> 5 writes in order on consecutive cycles.
- 2 pixels pending when clear_req pulses -> those 2 are written first, then 19200 writes at addr 0..19199 with data CLEAR_COLOR. clear_busy=1 and in_ready=0 throughout; a second clear_req mid-sweep is ignored; clear_busy falls after addr 19199 is written.
- Reset asserted during CLEAR at addr 100 -> from the next cycle fb_we=0, clear_busy=0, in_ready=1, and no further writes.
- 300 out-of-range pixels -> dropped_cnt=255, held there.

Source files
------------

// File: rtl/pixel_fb_writer_pkg.sv
// Shared definitions for the 160x120 pixel framebuffer writer: geometry,
// widths, state encoding and the linear address computation.
package pixel_fb_writer_pkg;

  localparam int X_MAX      = 160;
  localparam int Y_MAX      = 120;
  localparam int ADDR_W     = 15;
  localparam int COLOR_W    = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int PIX_COUNT  = X_MAX * Y_MAX;

  localparam logic [COLOR_W-1:0] CLEAR_COLOR = 9'd0;
  localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(PIX_COUNT - 1);
  localparam logic [ADDR_W-1:0]  SWEEP_END   = ADDR_W'(PIX_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } fbw_state_e;

  // Row-major linear address; with X_MAX=160 this reduces to (y<<7)+(y<<5)+x.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return ADDR_W'(y) * ADDR_W'(X_MAX) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_fb_writer_if.sv
// Pixel-stream input bundle and framebuffer write-port bundle.
// Pixel side: a pixel transfers on an edge with in_valid && in_ready; fb side: a write completes on an edge with fb_we && !fb_stall.
interface pix_stream_if;
  import pixel_fb_writer_pkg::*;

  logic [7:0]         in_x;
  logic [6:0]         in_y;
  logic [COLOR_W-1:0] in_color;
  logic               in_valid;
  logic               in_ready;
  logic               clear_req;
  logic               clear_busy;
  logic [7:0]         dropped_cnt;

  modport master (
    output in_x, in_y, in_color, in_valid, clear_req,
    input  in_ready, clear_busy, dropped_cnt
  );

  modport slave (
    input  in_x, in_y, in_color, in_valid, clear_req,
    output in_ready, clear_busy, dropped_cnt
  );
endinterface

interface fb_write_if;
  import pixel_fb_writer_pkg::*;

  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_we;
  logic               fb_stall;

  modport master (
    output fb_addr, fb_data, fb_we,
    input  fb_stall
  );

  modport slave (
    input  fb_addr, fb_data, fb_we,
    output fb_stall
  );
endinterface

// File: rtl/pixel_fb_writer_sync_fifo.sv
// Small synchronous FIFO with the head entry presented combinationally.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Converts the (x, y, color) pixel stream into buffered framebuffer writes
// and runs a full-screen clear sweep on request.
module pixel_fb_writer
  import pixel_fb_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  pix_stream_if.slave pix,
  fb_write_if.master  fb,
  output fbw_state_e  dbg_state_o
);
  localparam int ENTRY_W = ADDR_W + COLOR_W;

  fbw_state_e         state_q;
  logic [ADDR_W-1:0]  sweep_q;
  logic [ADDR_W-1:0]  fb_addr_q;
  logic [COLOR_W-1:0] fb_data_q;
  logic               fb_we_q;
  logic [7:0]         dropped_q;

  logic               in_range;
  logic               in_ready;
  logic               push;
  logic               drop;
  logic               out_free;
  logic               write_done;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;

  assign in_range   = (pix.in_x < 8'(X_MAX)) && (pix.in_y < 7'(Y_MAX));
  assign in_ready   = (state_q == ST_IDLE) && !fifo_full;
  assign push       = pix.in_valid && in_ready && in_range;
  assign drop       = pix.in_valid && !push;
  assign out_free   = !fb_we_q || !fb.fb_stall;
  assign write_done = fb_we_q && !fb.fb_stall;
  assign pop        = out_free && !fifo_empty && (state_q != ST_CLEAR);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({pix_addr(pix.in_x, pix.in_y), pix.in_color}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sweep_q   <= '0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      dropped_q <= '0;
    end else begin
      if (drop && (dropped_q != 8'hFF)) dropped_q <= dropped_q + 8'd1;

      // sweep_q counts addresses already loaded into the output stage.
      if (out_free) begin
        if ((state_q == ST_CLEAR) && (sweep_q != SWEEP_END)) begin
          fb_we_q   <= 1'b1;
          fb_addr_q <= sweep_q;
          fb_data_q <= CLEAR_COLOR;
          sweep_q   <= sweep_q + 1'b1;
        end else if ((state_q != ST_CLEAR) && !fifo_empty) begin
          fb_we_q   <= 1'b1;
          fb_addr_q <= fifo_head[ENTRY_W-1:COLOR_W];
          fb_data_q <= fifo_head[COLOR_W-1:0];
        end else begin
          fb_we_q   <= 1'b0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (pix.clear_req) begin
            state_q <= ST_DRAIN;
            sweep_q <= '0;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty && out_free) state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (write_done && (fb_addr_q == LAST_ADDR)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pix.in_ready    = in_ready;
  assign pix.clear_busy  = (state_q != ST_IDLE);
  assign pix.dropped_cnt = dropped_q;
  assign fb.fb_addr      = fb_addr_q;
  assign fb.fb_data      = fb_data_q;
  assign fb.fb_we        = fb_we_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Bench for pixel_fb_writer: directed cases plus random pixel traffic scored
// against a queue of expected framebuffer writes.
module tb_pixel_fb_writer;
  import pixel_fb_writer_pkg::*;

  localparam int W = ADDR_W + COLOR_W;

  logic       clk = 1'b0;
  logic       reset;
  fbw_state_e dbg_state;

  pix_stream_if p();
  fb_write_if   f();

  pixel_fb_writer dut (
    .clk         (clk),
    .reset       (reset),
    .pix         (p.slave),
    .fb          (f.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int  checks    = 0;
  int  failures  = 0;
  bit  mon_en    = 1'b0;
  bit  busy_m    = 1'b0;
  bit  stage_m   = 1'b0;
  int  dropped_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int x, input int y, input logic [COLOR_W-1:0] c);
    return {ADDR_W'(y * X_MAX + x), c};
  endfunction

  // ---------------- reference model / monitor ----------------
  // Runs between edges: checks the state left by the previous edge, then
  // predicts what the coming edge does with the inputs now being driven.
  always @(negedge clk) begin
    int fifo_cnt;
    bit ready_m, in_rng, acc, done;
    logic [W-1:0] exp_w;
    if (mon_en) begin
      fifo_cnt = exp_q.size() - int'(stage_m);
      ready_m  = !busy_m && (fifo_cnt < FIFO_DEPTH);
      check("in_ready", p.in_ready, ready_m);
      check("clear_busy", p.clear_busy, busy_m);
      check("dropped_cnt", p.dropped_cnt, dropped_m);
      if (!busy_m) check("fb_we", f.fb_we, stage_m);

      in_rng = (int'(p.in_x) < X_MAX) && (int'(p.in_y) < Y_MAX);
      acc    = p.in_valid && ready_m && in_rng;
      if (p.in_valid && !acc && dropped_m < 255) dropped_m++;

      done = 1'b0;
      if (f.fb_we && !f.fb_stall) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", {f.fb_addr, f.fb_data}, 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check("fb_write", {f.fb_addr, f.fb_data}, exp_w);
          if (busy_m && exp_q.size() == 0) done = 1'b1;
        end
      end

      if (!busy_m && (!stage_m || !f.fb_stall)) stage_m = (fifo_cnt > 0);
      if (acc) exp_q.push_back(exp_word(p.in_x, p.in_y, p.in_color));

      if (done) begin
        busy_m  = 1'b0;
        stage_m = 1'b0;
      end else if (!busy_m && p.clear_req) begin
        busy_m = 1'b1;
        for (int a = 0; a < PIX_COUNT; a++) exp_q.push_back({ADDR_W'(a), CLEAR_COLOR});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input bit v, input int x, input int y, input logic [COLOR_W-1:0] c);
    p.in_valid = v;
    p.in_x     = 8'(x);
    p.in_y     = 7'(y);
    p.in_color = c;
  endtask

  task automatic send_pix(input int x, input int y, input logic [COLOR_W-1:0] c);
    set_pix(1'b1, x, y, c);
    step();
    p.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    bit hit;
    reset       = 1'b1;
    set_pix(1'b0, 0, 0, '0);
    p.clear_req = 1'b0;
    f.fb_stall  = 1'b0;
    repeat (3) step();

    check("rst_fb_we", f.fb_we, 0);
    check("rst_fb_addr", f.fb_addr, 0);
    check("rst_fb_data", f.fb_data, 0);
    check("rst_dropped", p.dropped_cnt, 0);
    check("rst_busy", p.clear_busy, 0);
    check("rst_in_ready", p.in_ready, 1);
    check("rst_state", dbg_state, ST_IDLE);
    reset  = 1'b0;
    mon_en = 1'b1;

    // single pixel latency and address
    send_pix(5, 2, 9'h1A5);
    check("t1_we_at_accept", f.fb_we, 0);
    step();
    check("t1_we", f.fb_we, 1);
    check("t1_addr", f.fb_addr, 325);
    check("t1_data", f.fb_data, 9'h1A5);
    step();
    check("t1_we_one_cycle", f.fb_we, 0);
    check("t1_dropped", p.dropped_cnt, 0);

    // coordinate boundaries
    send_pix(159, 119, 9'h0F3);
    step();
    check("corner_addr", f.fb_addr, 19199);
    check("corner_we", f.fb_we, 1);
    send_pix(160, 0, 9'h111);
    send_pix(0, 120, 9'h122);
    repeat (3) step();
    check("oor_dropped", p.dropped_cnt, 2);

    // back-pressure: 1 in output stage + 4 in FIFO, 6th discarded
    f.fb_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_pix(1'b1, i, 10, 9'(i + 1));
      step();
      if (i == 4) check("stall_ready_low", p.in_ready, 0);
    end
    p.in_valid = 1'b0;
    check("stall_dropped", p.dropped_cnt, 3);
    step();
    f.fb_stall = 1'b0;
    check("stall_hold_we", f.fb_we, 1);
    check("stall_hold_addr", f.fb_addr, 1600);
    for (int k = 1; k < 5; k++) begin
      step();
      check("drain_addr", f.fb_addr, 1600 + k);
    end
    step();
    check("drain_done_we", f.fb_we, 0);

    // random traffic with random back-pressure
    repeat (400) begin
      f.fb_stall = ($urandom_range(0, 9) < 3);
      set_pix($urandom_range(0, 9) < 6, $urandom_range(0, 175), $urandom_range(0, 127),
              9'($urandom_range(0, 511)));
      step();
    end
    p.in_valid = 1'b0;
    f.fb_stall = 1'b0;
    repeat (10) step();

    // clear sweep with pending pixels; a pixel on the request edge is still taken
    f.fb_stall = 1'b1;
    send_pix(7, 7, 9'h055);
    send_pix(8, 7, 9'h0AA);
    set_pix(1'b1, 9, 7, 9'h1FF);
    p.clear_req = 1'b1;
    step();
    p.clear_req = 1'b0;
    p.in_valid  = 1'b0;
    check("clr_busy_rise", p.clear_busy, 1);
    check("clr_ready_low", p.in_ready, 0);
    hit = 1'b0;
    for (int n = 0; n < 40000; n++) begin
      f.fb_stall  = ($urandom_range(0, 9) < 2);
      p.clear_req = (n == 3000);
      set_pix($urandom_range(0, 9) == 0, $urandom_range(0, 159), $urandom_range(0, 119),
              9'($urandom_range(0, 511)));
      step();
      if (!busy_m) begin
        hit = 1'b1;
        break;
      end
    end
    p.clear_req = 1'b0;
    p.in_valid  = 1'b0;
    f.fb_stall  = 1'b0;
    if (!hit) check("clear_timeout", p.clear_busy, 0);
    step();
    check("clr_left", exp_q.size(), 0);
    check("clr_busy_fall", p.clear_busy, 0);

    // reset during the sweep
    p.clear_req = 1'b1;
    step();
    p.clear_req = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (f.fb_we && f.fb_addr == 100) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("reach_addr100", f.fb_addr, 100);
    mon_en = 1'b0;
    reset  = 1'b1;
    step();
    check("mid_rst_we", f.fb_we, 0);
    check("mid_rst_busy", p.clear_busy, 0);
    check("mid_rst_ready", p.in_ready, 1);
    check("mid_rst_addr", f.fb_addr, 0);
    reset = 1'b0;
    exp_q.delete();
    busy_m    = 1'b0;
    stage_m   = 1'b0;
    dropped_m = 0;
    seen      = 0;
    repeat (20) begin
      step();
      if (f.fb_we) seen++;
    end
    check("post_rst_writes", seen, 0);
    mon_en = 1'b1;

    // dropped counter saturation
    repeat (300) begin
      set_pix(1'b1, $urandom_range(160, 255), $urandom_range(0, 127), 9'h1);
      step();
    end
    p.in_valid = 1'b0;
    check("sat_dropped", p.dropped_cnt, 255);
    repeat (5) send_pix(0, 127, 9'h2);
    step();
    check("sat_hold", p.dropped_cnt, 255);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
